// File: rtl/hdmi_timing_gen_if.sv
// Video timing bundle between the timing generator and the downstream fetch/format stage.
// The generator drives sync, enable and position; the downstream stage drives run.
interface hdmi_timing_gen_if;
    logic        run;
    logic        out_rgb_de;
    logic        out_rgb_hs;
    logic        out_rgb_vs;
    logic        frame_last_pix;
    logic        line_start;
    logic [11:0] h_pos;
    logic [11:0] v_pos;

    modport master (
        input  run,
        output out_rgb_de, out_rgb_hs, out_rgb_vs, frame_last_pix, line_start, h_pos, v_pos
    );

    modport slave (
        output run,
        input  out_rgb_de, out_rgb_hs, out_rgb_vs, frame_last_pix, line_start, h_pos, v_pos
    );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Raster timing generator for the HDMI output path: DE/HS/VS, line start and end-of-frame,
// all registered. The raster restarts at (0,0) whenever run drops.
module hdmi_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input logic               hdmiclk,
    input logic               rst_hdclk,
    hdmi_timing_gen_if.master vid
);

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_TOTAL  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] V_TOTAL  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] hcnt, vcnt;
    logic        h_wrap, v_wrap;
    logic        de_c, hs_c, vs_c, last_c, ls_c;

    assign h_wrap = (hcnt == H_TOTAL - 12'd1);
    assign v_wrap = (vcnt == V_TOTAL - 12'd1);

    // NOTE: state is written with <= so every register samples pre-edge values, whatever the block order.
    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (!vid.run) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_wrap) begin
            hcnt <= '0;
            vcnt <= v_wrap ? 12'd0 : vcnt + 12'd1;
        end else begin
            hcnt <= hcnt + 12'd1;
        end
    end

    // VS follows vcnt alone, so it can only toggle when hcnt wraps to 0.
    always_comb begin
        de_c   = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_c   = (hcnt >= HS_START) && (hcnt < HS_END);
        vs_c   = (vcnt >= VS_START) && (vcnt < VS_END);
        last_c = h_wrap && v_wrap;
        ls_c   = (hcnt == 12'd0);
    end

    // Outputs show the pixel the counters held before this edge; idle drives syncs inactive.
    always_ff @(posedge hdmiclk or posedge rst_hdclk) begin
        if (rst_hdclk || !vid.run) begin
            vid.out_rgb_de     <= 1'b0;
            vid.out_rgb_hs     <= ~HS_POL;
            vid.out_rgb_vs     <= ~VS_POL;
            vid.frame_last_pix <= 1'b0;
            vid.line_start     <= 1'b0;
            vid.h_pos          <= '0;
            vid.v_pos          <= '0;
        end else begin
            vid.out_rgb_de     <= de_c;
            vid.out_rgb_hs     <= hs_c ? HS_POL : ~HS_POL;
            vid.out_rgb_vs     <= vs_c ? VS_POL : ~VS_POL;
            vid.frame_last_pix <= last_c;
            vid.line_start     <= ls_c;
            vid.h_pos          <= hcnt;
            vid.v_pos          <= vcnt;
        end
    end

endmodule
